count_bcd_display: RTL

- Downstream consumer of the 8-bit gated edge counter.
- Captures each new count value and converts it to three BCD digits with a sequential double-dabble.
- Time-multiplexes the digits onto a 4-digit, active-low, common-anode 7-segment display.
- Sits between the frequency-count stage and the board display pins.

---
 rtl/count_disp_pkg.sv | 32 +++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/count_bcd_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/count_disp_pkg.sv
// Shared types and constants for the count-to-7-segment display path:
// FSM states, BCD geometry, blank segment code and the double-dabble adjust step.
package count_disp_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_BCD    = 3;
  localparam int unsigned BCD_BITS   = BCD_W * NUM_BCD;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned PRESC_W    = 16;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_BITS-1:0] dabble_adjust(input logic [BCD_BITS-1:0] bcd);
    logic [BCD_BITS-1:0] r;
    r = bcd;
    for (int i = 0; i < int'(NUM_BCD); i++) begin
      if (bcd[i*BCD_W +: BCD_W] >= BCD_W'(5))
        r[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + BCD_W'(3);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module bcd_to_seg7
  import count_disp_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      4'd0:    seg_c = 7'b1000000;
      4'd1:    seg_c = 7'b1111001;
      4'd2:    seg_c = 7'b0100100;
      4'd3:    seg_c = 7'b0110000;
      4'd4:    seg_c = 7'b0011001;
      4'd5:    seg_c = 7'b0010010;
      4'd6:    seg_c = 7'b0000010;
      4'd7:    seg_c = 7'b1111000;
      4'd8:    seg_c = 7'b0000000;
      4'd9:    seg_c = 7'b0010000;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_bcd_display.sv
// Captures count strobes, converts to 3 BCD digits by sequential double-dabble and
// scans them onto a 4-digit active-low 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               count_valid,
  output logic               busy,
  output logic [SEG_W-1:0]   seg,
  output logic [3:0]         an,
  output logic               dp
);

  localparam int unsigned CNT_W = (COUNT_W > 1) ? $clog2(COUNT_W) : 1;
  localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(COUNT_W - 1);
  localparam logic [PRESC_W-1:0] SCAN_LAST  = PRESC_W'(SCAN_DIV - 1);

  state_t state, state_next;

  logic [COUNT_W-1:0]  bin;
  logic [BCD_BITS-1:0] bcd;
  logic [BCD_BITS-1:0] bcd_adj;
  logic [CNT_W-1:0]    shift_cnt;
  logic [COUNT_W-1:0]  pend_val;
  logic                pend_flag;
  logic [BCD_BITS-1:0] disp;

  logic               start;
  logic [COUNT_W-1:0] start_val;
  logic               shift_en;
  logic               capture_pend;
  logic               commit;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_valid) state_next = SHIFT;
      SHIFT:   if (shift_cnt == LAST_SHIFT) state_next = COMMIT;
      COMMIT:  state_next = (pend_flag || count_valid) ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode; a strobe landing on COMMIT beats the older pending value
  always_comb begin
    start        = 1'b0;
    start_val    = count_in;
    shift_en     = 1'b0;
    capture_pend = 1'b0;
    commit       = 1'b0;
    case (state)
      IDLE:   start = count_valid;
      SHIFT: begin
        shift_en     = 1'b1;
        capture_pend = count_valid;
      end
      COMMIT: begin
        commit    = 1'b1;
        start     = pend_flag || count_valid;
        start_val = count_valid ? count_in : pend_val;
      end
      default: ;
    endcase
  end

  assign bcd_adj = dabble_adjust(bcd);

  // Conversion datapath and busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (start) begin
        bin       <= start_val;
        bcd       <= '0;
        shift_cnt <= '0;
      end else if (shift_en) begin
        bcd       <= {bcd_adj[BCD_BITS-2:0], bin[COUNT_W-1]};
        bin       <= {bin[COUNT_W-2:0], 1'b0};
        shift_cnt <= shift_cnt + CNT_W'(1);
      end
    end
  end

  // One-deep pending slot, latest strobe wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_val  <= '0;
      pend_flag <= 1'b0;
    end else if (capture_pend) begin
      pend_val  <= count_in;
      pend_flag <= 1'b1;
    end else if (commit) begin
      pend_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       disp <= '0;
    else if (commit) disp <= bcd;
  end

  logic [PRESC_W-1:0] presc;
  logic [IDX_W-1:0]   idx;
  logic               tick;

  assign tick = (presc == SCAN_LAST);

  // Scan prescaler, digit index and anode drive; an follows the pre-increment index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      an    <= 4'hF;
    end else begin
      presc <= tick ? '0 : presc + PRESC_W'(1);
      if (tick) begin
        idx <= idx + IDX_W'(1);
        an  <= ~(4'b0001 << idx);
      end
    end
  end

  logic [IDX_W-1:0] sel;
  logic [BCD_W-1:0] nibble;
  logic             blank;
  logic [SEG_W-1:0] dec_seg;
  logic [BCD_W-1:0] hund;
  logic [BCD_W-1:0] tens;

  assign hund = disp[2*BCD_W +: BCD_W];
  assign tens = disp[BCD_W +: BCD_W];

  // Digit select tracks the anode that is (or is about to be) lit
  always_comb begin
    sel    = tick ? idx : idx - IDX_W'(1);
    nibble = '0;
    blank  = 1'b0;
    case (sel)
      2'd0: nibble = disp[BCD_W-1:0];
      2'd1: begin
        nibble = tens;
`ifdef LEADING_ZERO_BLANK_EN
        blank  = (hund == '0) && (tens == '0);
`endif
      end
      2'd2: begin
        nibble = hund;
`ifdef LEADING_ZERO_BLANK_EN
        blank  = (hund == '0);
`endif
      end
      default: blank = 1'b1;
    endcase
  end

  bcd_to_seg7 u_dec (
    .digit (nibble),
    .seg_c (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      seg <= blank ? SEG_BLANK : dec_seg;
      dp  <= 1'b1;
    end
  end

endmodule
